// File: rtl/dmem_lsu.sv
// Load/store unit between MEM stage and dmem; splits stores dmem cannot mask and crossing loads into beats.
// Latency accept->resp: 2 (simple), nbytes+1 (split store), 3 (crossing load); req_ready low stalls upstream.
module dmem_lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              mem_we,
   output logic [3:0]        mem_amp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_ACCESS, S_SBYTE, S_LLO, S_LHI, S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              we_q, we_d;
   logic              uns_q, uns_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [1:0]        k_q, k_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;

   function automatic logic [2:0] nbytes(input logic [1:0] sz);
      logic [2:0] n;
      case (sz)
         2'b00:   n = 3'd1;
         2'b01:   n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                              input logic [1:0] sz, input logic uns);
      logic [XLEN-1:0] r;
      case (sz)
         2'b00:   r = {{(XLEN-8){~uns & raw[7]}}, raw[7:0]};
         2'b01:   r = {{(XLEN-16){~uns & raw[15]}}, raw[15:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

   logic [1:0]        req_off, off_q;
   logic [2:0]        req_nb;
   logic              req_repr, req_cross;
   logic [ADDR_W-1:0] beat_addr;
   logic [XLEN-1:0]   load_raw, sbyte_raw;
   logic [5:0]        lo_shift;

   assign req_off   = req_addr[1:0];
   assign off_q     = addr_q[1:0];
   assign req_nb    = nbytes(req_size);
   assign req_repr  = (req_size == 2'b00) || (req_size == 2'b01 && !req_off[0]) ||
                      (req_size[1] && req_off == 2'b00);
   assign req_cross = ({1'b0, req_off} + req_nb) > 3'd4;
   assign beat_addr = addr_q + ADDR_W'(k_q);
   assign load_raw  = mem_rdata >> {off_q, 3'b000};
   assign sbyte_raw = wdata_q >> {k_q, 3'b000};
   // Upper lanes of a crossing load sit just above the 4-off bytes already latched.
   assign lo_shift  = 6'd32 - {1'b0, off_q, 3'b000};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      we_d       = we_q;
      uns_d      = uns_q;
      wdata_d    = wdata_q;
      k_d        = k_q;
      lo_d       = lo_q;
      rdata_d    = rdata_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      mem_amp    = 4'b0000;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = req_size;
               we_d    = req_we;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               k_d     = 2'd0;
               if (req_we)
                  state_d = req_repr ? S_ACCESS : S_SBYTE;
               else
                  state_d = req_cross ? S_LLO : S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_addr = addr_q;
            if (we_q) begin
               mem_we  = 1'b1;
               rdata_d = '0;
               case (size_q)
                  2'b00: begin
                     mem_amp   = 4'b0001 << off_q;
                     mem_wdata = {{(XLEN-8){1'b0}}, wdata_q[7:0]};
                  end
                  2'b01: begin
                     mem_amp   = off_q[1] ? 4'b1100 : 4'b0011;
                     mem_wdata = {{(XLEN-16){1'b0}}, wdata_q[15:0]};
                  end
                  default: begin
                     mem_amp   = 4'b1111;
                     mem_wdata = wdata_q;
                  end
               endcase
            end else begin
               rdata_d = extend(load_raw, size_q, uns_q);
            end
            state_d = S_RESP;
         end
         S_SBYTE: begin
            mem_we    = 1'b1;
            mem_addr  = beat_addr;
            mem_amp   = 4'b0001 << beat_addr[1:0];
            mem_wdata = {{(XLEN-8){1'b0}}, sbyte_raw[7:0]};
            k_d       = k_q + 2'd1;
            if ({1'b0, k_q} == nbytes(size_q) - 3'd1) begin
               rdata_d = '0;
               state_d = S_RESP;
            end
         end
         S_LLO: begin
            mem_addr = addr_q;
            lo_d     = load_raw;
            state_d  = S_LHI;
         end
         S_LHI: begin
            mem_addr = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
            rdata_d  = extend(lo_q | (mem_rdata << lo_shift), size_q, uns_q);
            state_d  = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         k_q     <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         k_q     <= k_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
      end
   end

   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-level reference memory and per-request expectations checked every cycle.
module tb_dmem_lsu;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_amp;

   always #5 clk = ~clk;

   dmem_lsu #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_amp(mem_amp),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] dm [1024];
   logic [7:0]  rm [4096];
   assign mem_rdata = dm[mem_addr[11:2]];

   int checks = 0, failures = 0, cyc = 0, resp_cnt = 0, last_lat = 0, bad_amp = 0, acc_cyc = 0;
   logic [31:0] last_rdata;

   bit          m_busy = 0, m_we, m_uns, m_split, m_cross;
   int          m_acc, m_lat, m_nb;
   logic [31:0] m_addr, m_wdata, m_exp;

   int          nbeat;
   logic [3:0]  b_amp [8];
   logic [31:0] b_addr [8], b_wd [8];
   logic [3:0]  split_amp [4];
   logic [7:0]  split_byte [4];

   bit          wr_vld = 0;
   logic [9:0]  wr_idx;
   logic [3:0]  wr_amp;
   logic [31:0] wr_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic poke_word(input int idx, input logic [31:0] val);
      dm[idx] = val;
      for (int i = 0; i < 4; i++) rm[idx*4+i] = 8'(val >> (8*i));
   endtask

   task automatic model_accept();
      logic [11:0] bi;
      int off;
      bit repr;
      m_acc = cyc;  acc_cyc = cyc;  nbeat = 0;
      m_addr = req_addr;  m_wdata = req_wdata;  m_we = req_we;  m_uns = req_unsigned;
      m_nb = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
      off = int'(req_addr[1:0]);
      repr = (m_nb == 1) || (m_nb == 2 && off % 2 == 0) || (m_nb == 4 && off == 0);
      m_split = m_we && !repr;
      m_cross = !m_we && (off + m_nb > 4);
      if (m_we) m_lat = repr ? 2 : m_nb + 1;
      else      m_lat = m_cross ? 3 : 2;
      m_exp = 32'h0;
      if (!m_we) begin
         for (int i = 0; i < m_nb; i++) begin
            bi = 12'(m_addr + 32'(i));
            m_exp = m_exp | (32'(rm[bi]) << (8*i));
         end
         if (!m_uns && m_nb < 4 && m_exp[8*m_nb-1]) m_exp = m_exp | (32'hFFFF_FFFF << (8*m_nb));
      end
      m_busy = 1;
   endtask

   task automatic mon_step();
      int j;
      logic [11:0] bi;
      logic [31:0] ea;
      cyc++;
      wr_vld = 0;
      if (mem_we === 1'b1 && reset) begin
         wr_vld = 1;  wr_idx = mem_addr[11:2];  wr_amp = mem_amp;  wr_wd = mem_wdata;
         if (nbeat < 8) begin
            b_amp[nbeat] = mem_amp;  b_addr[nbeat] = mem_addr;  b_wd[nbeat] = mem_wdata;
         end
         nbeat++;
      end
      if (resp_valid === 1'b1) begin
         resp_cnt++;  last_rdata = resp_rdata;  last_lat = cyc - acc_cyc;
      end
      if (!reset) begin
         chk("rst_ready", 32'(req_ready), 32'd1);
         chk("rst_resp_valid", 32'(resp_valid), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         m_busy = 0;
      end else if (m_busy) begin
         j = cyc - m_acc;
         chk("busy_ready", 32'(req_ready), 32'd0);
         if (j == m_lat) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_mem_we", 32'(mem_we), 32'd0);
            chk("resp_rdata", resp_rdata, m_exp);
            m_busy = 0;
         end else begin
            chk("early_resp", 32'(resp_valid), 32'd0);
            chk("beat_we", 32'(mem_we), 32'(m_we));
            if (m_split)               ea = m_addr + 32'(j - 1);
            else if (m_cross && j == 2) ea = ((m_addr >> 2) + 32'd1) << 2;
            else                       ea = m_addr;
            chk("beat_addr", mem_addr, ea);
            if (m_we && m_split) begin
               bi = 12'(m_addr + 32'(j - 1));
               rm[bi] = 8'(m_wdata >> (8*(j-1)));
            end else if (m_we) begin
               for (int i = 0; i < m_nb; i++) begin
                  bi = 12'(m_addr + 32'(i));
                  rm[bi] = 8'(m_wdata >> (8*i));
               end
            end
         end
      end else begin
         chk("idle_ready", 32'(req_ready), 32'd1);
         chk("idle_resp_valid", 32'(resp_valid), 32'd0);
         chk("idle_mem_we", 32'(mem_we), 32'd0);
         if (req_valid) model_accept();
      end
   endtask

   task automatic dmem_write();
      if (wr_vld) begin
         case (wr_amp)
            4'b1111: dm[wr_idx] = wr_wd;
            4'b0011: dm[wr_idx][15:0]  = wr_wd[15:0];
            4'b1100: dm[wr_idx][31:16] = wr_wd[15:0];
            4'b0001: dm[wr_idx][7:0]   = wr_wd[7:0];
            4'b0010: dm[wr_idx][15:8]  = wr_wd[7:0];
            4'b0100: dm[wr_idx][23:16] = wr_wd[7:0];
            4'b1000: dm[wr_idx][31:24] = wr_wd[7:0];
            default: bad_amp++;
         endcase
         wr_vld = 0;
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit wait_resp);
      int old, n;
      @(posedge clk); #1;
      old = resp_cnt;
      req_we = we;  req_size = sz;  req_unsigned = uns;  req_addr = addr;  req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 30);
      chk("accept", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (wait_resp) begin
         n = 0;
         while (resp_cnt == old && n < 30) begin @(negedge clk); n++; end
         chk("resp_seen", 32'(resp_cnt != old), 32'd1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int mism, old;
      logic [31:0] a;
      reset = 1'b0;  req_valid = 1'b0;  req_we = 1'b0;  req_size = 2'b00;
      req_unsigned = 1'b0;  req_addr = '0;  req_wdata = '0;
      for (int i = 0; i < 1024; i++) poke_word(i, $urandom);
      split_amp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      split_byte = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      fork
         forever begin @(negedge clk); mon_step(); end
         forever begin @(posedge clk); dmem_write(); end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_rdata", resp_rdata, 32'h0);
      chk("reset_mem_amp", 32'(mem_amp), 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      @(posedge clk); #1 reset = 1'b1;

      do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 1);
      chk("sw_lat", 32'(last_lat), 32'd2);
      chk("sw_beats", 32'(nbeat), 32'd1);
      chk("sw_amp", 32'(b_amp[0]), 32'hF);
      chk("sw_wd", b_wd[0], 32'h11223344);
      chk("sw_word", dm[32'h40], 32'h11223344);

      do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 1);
      chk("sh_amp", 32'(b_amp[0]), 32'hC);
      chk("sh_wd", 32'(b_wd[0][15:0]), 32'hBEEF);
      chk("sh_word", dm[32'h40], 32'hBEEF3344);

      poke_word(32'h41, 32'h55667788);
      do_req(1'b1, 2'b10, 1'b0, 32'h101, 32'hAABBCCDD, 1);
      chk("ssplit_lat", 32'(last_lat), 32'd5);
      chk("ssplit_beats", 32'(nbeat), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("ssplit_addr", b_addr[i], 32'h101 + 32'(i));
         chk("ssplit_amp", 32'(b_amp[i]), 32'(split_amp[i]));
         chk("ssplit_byte", 32'(b_wd[i][7:0]), 32'(split_byte[i]));
      end
      chk("ssplit_word0", dm[32'h40], 32'hBBCCDD44);
      chk("ssplit_word1", dm[32'h41], 32'h556677AA);

      poke_word(32'h40, 32'h80000000);
      do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1);
      chk("lb", last_rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1);
      chk("lbu", last_rdata, 32'h00000080);
      poke_word(32'h40, 32'h00AB8000);
      do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1);
      chk("lh_mis", last_rdata, 32'hFFFFAB80);
      chk("lh_lat", 32'(last_lat), 32'd2);

      poke_word(32'h3F, 32'h55667788);
      poke_word(32'h40, 32'h11223344);
      do_req(1'b0, 2'b10, 1'b0, 32'h0FE, 32'h0, 1);
      chk("lw_cross", last_rdata, 32'h33445566);
      chk("lw_cross_lat", 32'(last_lat), 32'd3);
      do_req(1'b0, 2'b11, 1'b1, 32'h0FE, 32'h0, 1);
      chk("size11_cross", last_rdata, 32'h33445566);

      for (int t = 0; t < 400; t++) begin
         a = ($urandom_range(0, 7) == 0) ? $urandom : (32'h100 + 32'($urandom_range(0, 40)));
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, $urandom_range(0, 1) == 1);
      end
      repeat (10) @(negedge clk);

      poke_word(32'h40, 32'h11223344);
      poke_word(32'h41, 32'h55667788);
      @(posedge clk); #1;
      req_we = 1'b1;  req_size = 2'b10;  req_unsigned = 1'b0;
      req_addr = 32'h101;  req_wdata = 32'hAABBCCDD;  req_valid = 1'b1;
      begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (!req_ready && n < 30);
         chk("abort_accept", 32'(req_ready), 32'd1);
      end
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2 reset = 1'b0;
      old = resp_cnt;
      #1;
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_no_resp", 32'(resp_cnt - old), 32'd0);
      chk("abort_rdata", resp_rdata, 32'h0);
      chk("abort_word0", dm[32'h40], 32'h11CCDD44);
      chk("abort_word1", dm[32'h41], 32'h55667788);

      mism = 0;
      for (int i = 0; i < 4096; i++) begin
         if (8'(dm[i/4] >> (8*(i%4))) !== rm[i]) begin
            if (mism == 0) $display("first differing byte at %h: dmem %h, model %h",
                                    i, 8'(dm[i/4] >> (8*(i%4))), rm[i]);
            mism++;
         end
      end
      chk("mem_image", 32'(mism), 32'd0);
      chk("bad_amp", 32'(bad_amp), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
